// File: rtl/spi_rx_port.sv
// -----------------------------------------------------------------------------
// spi_rx_port
//
// SPI target-side receiver for the SoC byte link. An external mode-0 master
// clocks bytes in on SCK/MOSI while CS is low. Each byte is tagged with the
// D/C pin value seen at its 8th rising edge and queued in a small FIFO. The
// z8086 drains the FIFO through two I/O ports using the usual
// rd/wr/io/ready handshake.
//
//   PORT   (read)  : {1'b1, 6'b0, dc, byte} and pop, or 16'h0000 when empty
//   PORT   (write) : loads the MISO reply byte (macro on), otherwise ignored
//   PORT+1 (read)  : {8'b0, overrun, cs_active, 1'b0, count[4:0]}
//   PORT+1 (write) : wdata[7]=1 clears the sticky overrun flag
//
// Ports
//   clk, reset_n            system clock, asynchronous active-low reset
//   addr, rd, wr, io, word  CPU access (word is ignored)
//   wdata / rdata           CPU write data / registered read data
//   ready                   one-cycle completion pulse after an access
//   spi_sck/mosi/cs_n/dc    asynchronous SPI pins, synchronized internally
//   rx_avail                FIFO non-empty
//   spi_miso                reply data (only with SPI_RX_MISO_EN)
//
// Optional feature macro: SPI_RX_MISO_EN adds the spi_miso port and the
// reply register / TX shifter.
// -----------------------------------------------------------------------------
module spi_rx_port #(
    parameter logic [7:0] PORT        = 8'h08,
    parameter int         FIFO_DEPTH  = 8,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  addr,
    input  logic        rd,
    input  logic        wr,
    input  logic        io,
    input  logic        word,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        ready,
    input  logic        spi_sck,
    input  logic        spi_mosi,
    input  logic        spi_cs_n,
    input  logic        spi_dc,
    output logic        rx_avail
`ifdef SPI_RX_MISO_EN
    ,
    output logic        spi_miso
`endif
);

    localparam int              AW       = $clog2(FIFO_DEPTH);
    localparam logic [7:0]      PORT_ST  = PORT + 8'd1;
    localparam logic [AW-1:0]   PTR_ONE  = AW'(1);
    localparam logic [AW:0]     CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]     CNT_FULL = (AW+1)'(FIFO_DEPTH);
    // Pin bundle order {sck, mosi, cs_n, dc}; idle is CS deasserted.
    localparam logic [3:0]      PIN_IDLE = 4'b0010;

    // -------------------------------------------------------------------------
    // Input synchronizers and edge detection
    // -------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0][3:0] r_sync;
    logic                        r_sck_d;
    logic                        r_cs_n_d;
    logic                        w_sck;
    logic                        w_mosi;
    logic                        w_cs_n;
    logic                        w_dc;
    logic                        w_cs_act;
    logic                        w_sck_rise;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync   <= {SYNC_STAGES{PIN_IDLE}};
            r_sck_d  <= 1'b0;
            r_cs_n_d <= 1'b1;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], spi_sck, spi_mosi, spi_cs_n, spi_dc};
            r_sck_d  <= w_sck;
            r_cs_n_d <= w_cs_n;
        end
    end

    assign w_sck      = r_sync[SYNC_STAGES-1][3];
    assign w_mosi     = r_sync[SYNC_STAGES-1][2];
    assign w_cs_n     = r_sync[SYNC_STAGES-1][1];
    assign w_dc       = r_sync[SYNC_STAGES-1][0];
    assign w_cs_act   = ~w_cs_n;
    assign w_sck_rise = w_sck & ~r_sck_d;

    // -------------------------------------------------------------------------
    // Byte assembly. A finished byte is staged in r_push_data for one cycle
    // before it is written into the FIFO.
    // -------------------------------------------------------------------------
    logic [2:0] r_bitcnt;
    logic [6:0] r_shift;
    logic       r_push;
    logic [8:0] r_push_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bitcnt    <= 3'd0;
            r_shift     <= 7'd0;
            r_push      <= 1'b0;
            r_push_data <= 9'd0;
        end else begin
            r_push <= 1'b0;
            if (!w_cs_act) begin
                // CS high (or just released): any partial byte is dropped.
                r_bitcnt <= 3'd0;
                r_shift  <= 7'd0;
            end else if (w_sck_rise) begin
                r_shift  <= {r_shift[5:0], w_mosi};
                r_bitcnt <= r_bitcnt + 3'd1;          // 7 -> 0 wraps naturally
                if (r_bitcnt == 3'd7) begin
                    r_push      <= 1'b1;
                    r_push_data <= {w_dc, r_shift, w_mosi};
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // CPU access decode
    // -------------------------------------------------------------------------
    logic        r_ready;
    logic [15:0] r_rdata;
    logic        w_sel_data;
    logic        w_sel_st;
    logic        w_hit;
    logic        w_rd;
    logic        w_wr;

    assign w_sel_data = (addr == PORT);
    assign w_sel_st   = (addr == PORT_ST);
    // The strobe is still held during the ready cycle; masking with r_ready
    // keeps one access from being answered twice.
    assign w_hit      = io & (rd | wr) & (w_sel_data | w_sel_st) & ~r_ready;
    assign w_rd       = w_hit & rd;
    assign w_wr       = w_hit & wr & ~rd;

    // -------------------------------------------------------------------------
    // FIFO
    // -------------------------------------------------------------------------
    logic [8:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          r_overrun;
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_push_ok;
    logic          w_ovf;
    logic          w_ovr_clr;
    logic [4:0]    w_count5;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CNT_FULL);
    assign w_pop     = w_rd & w_sel_data & ~w_empty;
    // A pop in the same cycle frees the head slot, so a full FIFO still
    // accepts the push (write and read hit the same slot; read sees old data).
    assign w_push_ok = r_push & (~w_full | w_pop);
    assign w_ovf     = r_push & w_full & ~w_pop;
    assign w_ovr_clr = w_wr & w_sel_st & wdata[7];
    assign w_count5  = 5'(r_count);

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wptr] <= r_push_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
            // An overflow in the same cycle as a clear keeps the flag set.
            if (w_ovf) begin
                r_overrun <= 1'b1;
            end else if (w_ovr_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Read data / ready
    // -------------------------------------------------------------------------
    logic [15:0] w_rdata_nxt;

    always_comb begin
        w_rdata_nxt = 16'h0000;
        if (w_sel_data) begin
            if (!w_empty) begin
                w_rdata_nxt = {1'b1, 6'b0, r_mem[r_rptr]};
            end
        end else begin
            w_rdata_nxt = {8'h00, r_overrun, w_cs_act, 1'b0, w_count5};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ready <= 1'b0;
            r_rdata <= 16'h0000;
        end else begin
            r_ready <= w_hit;
            if (w_rd) begin
                r_rdata <= w_rdata_nxt;
            end
        end
    end

    assign ready    = r_ready;
    assign rdata    = r_rdata;
    assign rx_avail = ~w_empty;

`ifdef SPI_RX_MISO_EN
    // -------------------------------------------------------------------------
    // Reply shifter. The reply byte is loaded on CS falling and again at the
    // falling SCK edge that follows a completed byte (bit counter back at 0),
    // so its MSB is on the pin before the master's next rising edge.
    // -------------------------------------------------------------------------
    logic [7:0] r_reply;
    logic [7:0] r_tx_sh;
    logic       w_sck_fall;
    logic       w_cs_fall;

    assign w_sck_fall = ~w_sck & r_sck_d;
    assign w_cs_fall  = ~w_cs_n & r_cs_n_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_reply <= 8'h00;
            r_tx_sh <= 8'h00;
        end else begin
            if (w_wr && w_sel_data) begin
                r_reply <= wdata[7:0];
            end
            if (w_cs_fall) begin
                r_tx_sh <= r_reply;
            end else if (w_cs_act && w_sck_fall) begin
                r_tx_sh <= (r_bitcnt == 3'd0) ? r_reply : {r_tx_sh[6:0], 1'b0};
            end
        end
    end

    assign spi_miso = w_cs_act & r_tx_sh[7];
`endif

    // word and the upper write-data bits have no function in this block.
    logic w_unused_ok;
    assign w_unused_ok = ^{word, wdata[15:8], wdata[6:0]};

endmodule

// File: tb/tb_spi_rx_port.sv
module tb_spi_rx_port;

    localparam logic [7:0] PORT  = 8'h08;
    localparam int         DEPTH = 8;
    localparam int         S     = 2;
    localparam int         HALF  = 5;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  addr;
    logic        rd, wr, io, word;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        ready;
    logic        spi_sck, spi_mosi, spi_cs_n, spi_dc;
    logic        rx_avail;
`ifdef SPI_RX_MISO_EN
    logic        spi_miso;
`endif

    spi_rx_port #(.PORT(PORT), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(S)) dut (
        .clk(clk), .reset_n(reset_n), .addr(addr), .rd(rd), .wr(wr), .io(io),
        .word(word), .wdata(wdata), .rdata(rdata), .ready(ready),
        .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_cs_n(spi_cs_n),
        .spi_dc(spi_dc), .rx_avail(rx_avail)
`ifdef SPI_RX_MISO_EN
        , .spi_miso(spi_miso)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    typedef struct { bit is_rd; logic [7:0] a; logic [15:0] v; } exp_t;
    logic [8:0]  mq[$];          // queued {dc, byte}
    bit          m_ovr;
    bit          m_cs_act;
    logic [15:0] m_last;         // last value returned by a read
    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_ready = 0;
    logic [7:0]  miso_cap;

    function automatic logic [15:0] m_status();
        return {8'h00, m_ovr, m_cs_act, 1'b0, 5'(mq.size())};
    endfunction

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    task automatic model_push(input logic [8:0] e);
        if (mq.size() < DEPTH) mq.push_back(e);
        else m_ovr = 1'b1;
    endtask

    task automatic model_reset();
        mq.delete();
        exp_q.delete();
        m_ovr  = 1'b0;
        m_last = 16'h0000;
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        exp_t e;
        n_cmp++;
        if (rx_avail !== (mq.size() != 0)) begin
            n_bad++;
            $display("FAIL rx_avail: got %b want %b", rx_avail, mq.size() != 0);
        end
        if (ready === 1'b1) begin
            n_ready++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_ready: got 1 want 0");
            end else begin
                e = exp_q.pop_front();
                if (rdata !== e.v) begin
                    n_bad++;
                    $display("FAIL rdata a=%h rd=%0d: got %h want %h", e.a, e.is_rd, rdata, e.v);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cpu_begin(input bit is_rd, input logic [7:0] a, input logic [15:0] wd);
        io    = 1'b1;
        rd    = is_rd;
        wr    = ~is_rd;
        addr  = a;
        wdata = wd;
        word  = 1'($urandom_range(0, 1));
    endtask

    // Called just after the edge that recognizes the access.
    task automatic cpu_finish(input bit is_rd, input logic [7:0] a, input logic [15:0] wd,
                              input logic [15:0] lit, input bit has_lit, input string nm);
        exp_t        e;
        logic [15:0] v;
        logic [8:0]  h;
        if (a != PORT && a != PORT + 8'd1) return;
        if (is_rd) begin
            if (a == PORT) begin
                if (mq.size() != 0) begin
                    h = mq.pop_front();
                    v = {1'b1, 6'b0, h};
                end else v = 16'h0000;
            end else v = m_status();
            m_last = v;
            if (has_lit) chk(nm, v, lit);
        end else begin
            if (a == PORT + 8'd1 && wd[7]) m_ovr = 1'b0;
            v = m_last;
        end
        e.is_rd = is_rd; e.a = a; e.v = v;
        exp_q.push_back(e);
    endtask

    task automatic cpu_end();
        io = 1'b0; rd = 1'b0; wr = 1'b0;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL ready_missing: got 0 want 1");
            exp_q.delete();
        end
    endtask

    task automatic cpu_acc(input bit is_rd, input logic [7:0] a, input logic [15:0] wd,
                           input logic [15:0] lit, input bit has_lit, input string nm);
        cpu_begin(is_rd, a, wd);
        tick(1);
        cpu_finish(is_rd, a, wd, lit, has_lit, nm);
        tick(1);
        cpu_end();
        tick(1);
    endtask

    task automatic cs_low();
        spi_cs_n = 1'b0; m_cs_act = 1'b1;
        tick(HALF);
    endtask

    task automatic cs_high();
        spi_cs_n = 1'b1;
        tick(S + 3);
        m_cs_act = 1'b0;
    endtask

    // MSB-first; DC is random except at the last bit. With pop_land a data
    // read is recognized on the very edge at which the new entry lands.
    task automatic send_bits(input logic [7:0] b, input bit d, input int nbits, input bit pop_land);
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = b[7-i];
            spi_dc   = (i == 7) ? d : 1'($urandom_range(0, 1));
            tick(HALF);
`ifdef SPI_RX_MISO_EN
            miso_cap = {miso_cap[6:0], spi_miso};
`endif
            spi_sck = 1'b1;
            if (i == 7) begin
                tick(S + 1);
                if (pop_land) begin
                    cpu_begin(1'b1, PORT, 16'h0);
                    tick(1);
                    cpu_finish(1'b1, PORT, 16'h0, 16'h0, 1'b0, "");
                    model_push({d, b});
                    tick(1);
                    cpu_end();
                end else begin
                    tick(1);
                    model_push({d, b});
                end
            end
            tick(HALF);
            spi_sck = 1'b0;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("rst_rdata", rdata, 16'h0000);
        chk("rst_ready", {15'd0, ready}, 16'h0000);
        chk("rst_rx_avail", {15'd0, rx_avail}, 16'h0000);
`ifdef SPI_RX_MISO_EN
        chk("rst_miso", {15'd0, spi_miso}, 16'h0000);
`endif
        tick(3);
        reset_n = 1'b1;
        tick(2);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int r0;
        reset_n = 1'b0; addr = 8'h00; rd = 1'b0; wr = 1'b0; io = 1'b0; word = 1'b0;
        wdata = 16'h0; spi_sck = 1'b0; spi_mosi = 1'b0; spi_cs_n = 1'b1; spi_dc = 1'b0;
        m_cs_act = 1'b0; miso_cap = 8'h00;
        model_reset();
        tick(2);
        do_reset();
        cpu_acc(1, PORT + 8'd1, 16'h0, 16'h0000, 1, "init_status");

        // single byte
        cs_low();
        send_bits(8'hA5, 1'b1, 8, 1'b0);
        cs_high();
        chk("single_rx_avail", {15'd0, rx_avail}, 16'h0001);
        cpu_acc(1, PORT + 8'd1, 16'h0, 16'h0001, 1, "single_status");
        cpu_acc(1, PORT,        16'h0, 16'h81A5, 1, "single_data");
        cpu_acc(1, PORT + 8'd1, 16'h0, 16'h0000, 1, "single_status2");

        // fill and overflow
        cs_low();
        for (int i = 0; i < 9; i++) send_bits(8'(i), 1'b0, 8, 1'b0);
        cs_high();
        cpu_acc(1, PORT + 8'd1, 16'h0, 16'h0088, 1, "ovf_status");
        for (int i = 0; i < 8; i++) cpu_acc(1, PORT, 16'h0, 16'h8000 + 16'(i), 1, "ovf_data");
        cpu_acc(1, PORT, 16'h0, 16'h0000, 1, "ovf_empty_read");
        cpu_acc(0, PORT + 8'd1, 16'h0080, 16'h0, 0, "");
        cpu_acc(1, PORT + 8'd1, 16'h0, 16'h0000, 1, "ovf_cleared");

        // abort
        cs_low();
        send_bits(8'hFF, 1'b1, 5, 1'b0);
        cs_high();
        cs_low();
        send_bits(8'h3C, 1'b0, 8, 1'b0);
        cs_high();
        cpu_acc(1, PORT + 8'd1, 16'h0, 16'h0001, 1, "abort_status");
        cpu_acc(1, PORT,        16'h0, 16'h803C, 1, "abort_data");
        cpu_acc(1, PORT + 8'd1, 16'h0, 16'h0000, 1, "abort_status2");

        // simultaneous push/pop on a full FIFO, across the pointer wrap
        cs_low();
        for (int i = 0; i < 8; i++) send_bits(8'h40 + 8'(i), 1'(i), 8, 1'b0);
        send_bits(8'h77, 1'b1, 8, 1'b1);
        cs_high();
        cpu_acc(1, PORT + 8'd1, 16'h0, 16'h0008, 1, "simul_status");
        cpu_acc(1, PORT, 16'h0, 16'h8141, 1, "simul_second");
        for (int i = 0; i < 7; i++) cpu_acc(1, PORT, 16'h0, 16'h0, 0, "");

        // randomized traffic
        for (int it = 0; it < 50; it++) begin
            case ($urandom_range(0, 5))
                0, 1: begin
                    cs_low();
                    for (int k = $urandom_range(1, 3); k > 0; k--)
                        send_bits(8'($urandom), 1'($urandom), 8, $urandom_range(0, 3) == 0);
                    cs_high();
                end
                2:       cpu_acc(1, PORT, 16'h0, 16'h0, 0, "");
                3:       cpu_acc(1, PORT + 8'd1, 16'h0, 16'h0, 0, "");
                4:       cpu_acc(0, PORT + 8'd1, 16'($urandom), 16'h0, 0, "");
                default: cpu_acc(0, PORT, 16'($urandom), 16'h0, 0, "");
            endcase
        end
        while (mq.size() != 0) cpu_acc(1, PORT, 16'h0, 16'h0, 0, "");
        cpu_acc(0, PORT + 8'd1, 16'h0080, 16'h0, 0, "");

        // reset mid-byte, then decode check
        cs_low();
        send_bits(8'hC3, 1'b1, 4, 1'b0);
        do_reset();
        cs_high();
        cpu_acc(1, PORT + 8'd1, 16'h0, 16'h0000, 1, "postrst_status");
        r0 = n_ready;
        cpu_acc(1, PORT + 8'd2, 16'h0, 16'h0, 0, "");
        cpu_acc(0, PORT + 8'd2, 16'h0080, 16'h0, 0, "");
        chk("no_ready_port2", 16'(n_ready), 16'(r0));
        cs_low();
        send_bits(8'h11, 1'b0, 8, 1'b0);
        cs_high();
        cpu_acc(1, PORT, 16'h0, 16'h8011, 1, "postrst_data");

`ifdef SPI_RX_MISO_EN
        cpu_acc(0, PORT, 16'h005A, 16'h0, 0, "");
        cs_low();
        miso_cap = 8'h00;
        send_bits(8'hC3, 1'b1, 8, 1'b0);
        cs_high();
        chk("miso_byte", {8'h00, miso_cap}, 16'h005A);
        chk("miso_idle", {15'd0, spi_miso}, 16'h0000);
        cpu_acc(1, PORT, 16'h0, 16'h81C3, 1, "miso_rx_data");
`endif

        tick(2);
        $display("test done: total=%0d bad=%0d", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #900000;
        n_bad++;
        $display("FAIL timeout: got running want finished");
        $display("test done: total=%0d bad=%0d", n_cmp, n_bad);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/spi_rx_port.md
# spi_rx_port

SPI target-side receiver, the opposite end of the SPI byte link driven by the CPU's I/O port 7. It samples an external mode-0 master (SCK, MOSI, CS, D/C), assembles bytes tagged with their D/C bit into a small FIFO, and exposes them to the z8086 through two I/O ports using the same `rd`/`wr`/`io`/`ready` handshake as the other SoC peripherals. An optional reply shifter drives MISO.

## Interface
- `PORT`, 8'h08: base I/O address. `PORT` is the data port and `PORT+1` is the status port.
- `FIFO_DEPTH`, 8: number of FIFO entries. Must be a power of two from 2 to 16.
- `SYNC_STAGES`, 2: length of the synchronizer flop chain on every SPI input, 2 to 3.
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `addr` in 8: I/O address, bits [7:0] of the CPU address.
- `rd`, `wr`, `io`, `word` in 1 each: CPU access strobes.
- `wdata` in 16: CPU write data.
- `rdata` out 16: registered read data.
- `ready` out 1: one-cycle access-complete pulse.
- `spi_sck`, `spi_mosi`, `spi_cs_n`, `spi_dc` in 1 each: asynchronous pins, all synchronized internally.
- `rx_avail` out 1: high while the FIFO is non-empty.
- `spi_miso` out 1: present only with `SPI_RX_MISO_EN`.

## Operation
- Every pin passes through `SYNC_STAGES` flops. One further flop provides edge detection on the synchronized SCK and CS.
- Receive follows SPI mode 0 framing:
  - While synchronized CS is low, each SCK rising edge shifts MOSI in MSB-first and increments a 3-bit counter.
  - On the 8th rising edge, the byte plus the DC value sampled at that same edge is pushed to the FIFO and the counter returns to 0.
  - A CS rising edge, or CS high, clears the counter and shift register. A partial byte is discarded silently.
  - SCK edges seen while CS is high are ignored.
- FIFO push rules:
  - Push when not full.
  - When full, drop the byte and set sticky `overrun`.
  - A push and a pop in the same cycle both succeed, including when the FIFO is full. The count is unchanged.
  - Pointers wrap modulo `FIFO_DEPTH`.
- A CPU access is recognized only when `io & (rd|wr)` is set and `addr` equals `PORT` or `PORT+1`. Any other address produces no response: `ready` and `rdata` are untouched.
- Read of `PORT` while non-empty:
  - `rdata = {1'b1, 6'b0, dc, byte}`.
  - The head entry is popped.
- Read of `PORT` while empty: `rdata = 16'h0000`, no pop, and pointers are unchanged.
- Read of `PORT+1`: `rdata = {8'b0, overrun, cs_active, 1'b0, count[4:0]}`.
  - `count` is 0 to `FIFO_DEPTH`.
  - `cs_active` is the synchronized `~spi_cs_n`.
- Write to `PORT+1` with `wdata[7]=1` clears `overrun`. A push that overflows in the same cycle wins, so `overrun` stays set.
- Write to `PORT` is handled per `SPI_RX_MISO_EN` (see Configuration).
- The `word` input is ignored. Byte and word accesses behave identically.
- Reset values: `rdata` 0, `ready` 0, `rx_avail` 0, `spi_miso` 0, FIFO empty, `overrun` 0, counter 0, reply register 8'h00.
- Reset asserted mid-byte or mid-access clears everything. A partially received byte is lost.

## Timing
- `ready` is high exactly one cycle, the cycle after the recognized access cycle. `rdata` is valid in that same cycle and is held until the next recognized read.
- The CPU holds `rd`/`wr` until `ready`. The block responds once per access and does not re-trigger while the strobe is held in the `ready` cycle.
- Push latency: the entry is visible in the FIFO `SYNC_STAGES+2` clk cycles after the 8th SCK rising edge at the pin.
- `rx_avail` and `count` update on the cycle after the push or pop.
- SCK high and low time must each be at least `SYNC_STAGES+2` clk periods. The SoC master's 5-cycle half period satisfies this for both stage counts.
- DC and MOSI must be stable at the pins for at least 1 clk before the SCK rising edge.

## Configuration
- `SPI_RX_MISO_EN` defined:
  - The `spi_miso` port and an 8-bit reply register exist. Writing `PORT` loads the reply register from `wdata[7:0]`.
  - On a synchronized CS falling edge, and after each completed byte, the reply register is copied into the TX shifter and its MSB is driven on `spi_miso`.
  - Each synchronized SCK falling edge shifts the next bit out.
  - `spi_miso` is 0 while CS is high.
- `SPI_RX_MISO_EN` undefined:
  - No `spi_miso` port and no reply logic.
  - Writes to `PORT` are acknowledged with `ready` and otherwise ignored.

## Test plan
- **Single byte:** CS low, send 0xA5 with DC=1 at a 5-clk half period, CS high. Expected: `rx_avail`=1, status read=0x0001, data read=0x81A5, then status read=0x0000.
- **Fill and overflow:** send 9 bytes 0x00..0x08 without popping, `FIFO_DEPTH`=8. Expected: status=0x0088, and 8 data reads return 0x8000..0x8007 in order. A 9th read returns 0x0000. Writing 0x80 to `PORT+1` makes status 0x0000.
- **Abort:** CS rises after 5 bits of 0xFF, then 0x3C with DC=0 is sent. Expected: only 0x803C is read, and status shows count 1.
- **Simultaneous push/pop:** with the FIFO full, pop on the exact cycle the next push lands. Expected: count stays 8, `overrun`=0, and the order is preserved across the pointer wrap.
- **Reset and decode:** assert `reset_n`=0 mid-byte and release. Expected: all outputs 0 and status 0x0000. An access to `PORT+2` produces no `ready`.
- **MISO (macro on):** write 0x5A to `PORT`, then run a CS-low frame of 8 clocks. Expected: the master samples 0x5A on MISO, `spi_miso`=0 after CS goes high, and the received MOSI byte is still queued.
